phan_kenh_12kenh: RTL and testbench

//  - 12-channel registered demultiplexer: the write-side counterpart of the 12:1 channel selector.
//  - Accepts (channel index, data) words on a valid/ready stream and writes them into a
//    12-entry shadow bank; an atomic commit copies the shadow bank to 12 held outputs.
//  - Sits between a serial/time-multiplexed source and per-channel consumers (LEDs, 7-seg, regs).

---
 rtl/phan_kenh_pkg.sv | 18 +
 rtl/phan_kenh_bank.sv | 39 +++
 rtl/phan_kenh_12kenh.sv | 141 ++++++++++++++
 tb/tb_phan_kenh_12kenh.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/phan_kenh_pkg.sv
// Shared constants, FSM state type and channel-index legality check for the
// 12-channel registered demultiplexer.
package phan_kenh_pkg;

    localparam int unsigned NCH   = 12;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [0:0] {
        StFill,
        StCommit
    } state_e;

    // Channel index is legal when it addresses one of the NCH outputs.
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
        return sel < SEL_W'(NCH);
    endfunction

endpackage

// File: rtl/phan_kenh_bank.sv
// Shadow bank plus held output bank. Writes land in the shadow; copy_en moves
// the whole shadow into the outputs on one edge.
module phan_kenh_bank
    import phan_kenh_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [W-1:0]     wr_data,
    input  logic             copy_en,
    output logic [W-1:0]     q [NCH]
);

    logic [W-1:0] shadow_q [NCH];

    // Shadow write: one channel per accepted word, decoded per entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) shadow_q[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_en && (wr_sel == SEL_W'(k))) shadow_q[k] <= wr_data;
            end
        end
    end

    // Output bank: atomic copy of every shadow entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) q[k] <= '0;
        end else if (copy_en) begin
            for (int k = 0; k < NCH; k++) q[k] <= shadow_q[k];
        end
    end

endmodule

// File: rtl/phan_kenh_12kenh.sv
// 12-channel registered demultiplexer: (channel, data) words are written into a
// shadow bank and a commit copies the bank to 12 held outputs.
// Build option PHANKENH_AUTO_SCAN_EN: commit port removed, an internal counter
// picks the channel and a write to the last channel triggers the commit.
module phan_kenh_12kenh
    import phan_kenh_pkg::*;
#(
    parameter int unsigned W   = 4,
    parameter int unsigned NCH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [W-1:0]     in_data,
`ifndef PHANKENH_AUTO_SCAN_EN
    input  logic             commit,
`endif
    output logic [W-1:0]     o0,
    output logic [W-1:0]     o1,
    output logic [W-1:0]     o2,
    output logic [W-1:0]     o3,
    output logic [W-1:0]     o4,
    output logic [W-1:0]     o5,
    output logic [W-1:0]     o6,
    output logic [W-1:0]     o7,
    output logic [W-1:0]     o8,
    output logic [W-1:0]     o9,
    output logic [W-1:0]     o10,
    output logic [W-1:0]     o11,
    output logic             upd,
    output logic             err
);

    if (NCH != phan_kenh_pkg::NCH) begin : g_nch_check
        $error("NCH parameter must equal phan_kenh_pkg::NCH");
    end

    state_e           state_q, state_d;
    logic             xfer;
    logic             go;
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic             copy_en;
    logic             upd_q;
    logic             err_q, err_d;
    logic [W-1:0]     q [phan_kenh_pkg::NCH];

    assign xfer = in_valid & in_ready;

`ifdef PHANKENH_AUTO_SCAN_EN
    logic [SEL_W-1:0] cnt_q;

    // Scan counter: advances per accepted word, wraps after the last channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= (cnt_q == SEL_W'(phan_kenh_pkg::NCH - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    assign wr_sel = cnt_q;
    assign wr_en  = xfer;
    assign go     = xfer && (cnt_q == SEL_W'(phan_kenh_pkg::NCH - 1));
    assign err_d  = err_q;
`else
    assign wr_sel = in_sel;
    // Illegal indices are still accepted, but the data is dropped.
    assign wr_en  = xfer & sel_legal(in_sel);
    assign go     = commit;
    assign err_d  = err_q | (xfer & ~sel_legal(in_sel));
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFill;
        else     state_q <= state_d;
    end

    // FSM next state: COMMIT always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:   if (go) state_d = StCommit;
            StCommit: state_d = StFill;
            default:  state_d = StFill;
        endcase
    end

    // FSM outputs: stall the source during COMMIT and copy on its closing edge.
    always_comb begin
        in_ready = 1'b1;
        copy_en  = 1'b0;
        if (state_q == StCommit) begin
            in_ready = 1'b0;
            copy_en  = 1'b1;
        end
    end

    // Update pulse follows every copy; err is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            upd_q <= copy_en;
            err_q <= err_d;
        end
    end

    assign upd = upd_q;
    assign err = err_q;

    phan_kenh_bank #(
        .W (W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (in_data),
        .copy_en (copy_en),
        .q       (q)
    );

    assign o0  = q[0];
    assign o1  = q[1];
    assign o2  = q[2];
    assign o3  = q[3];
    assign o4  = q[4];
    assign o5  = q[5];
    assign o6  = q[6];
    assign o7  = q[7];
    assign o8  = q[8];
    assign o9  = q[9];
    assign o10 = q[10];
    assign o11 = q[11];

endmodule

// File: tb/tb_phan_kenh_12kenh.sv
// Directed bench for phan_kenh_12kenh: a vector table for the write/commit
// flow plus hand-written sequences for held commit and mid-COMMIT reset.
module tb_phan_kenh_12kenh;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sel;
    logic [3:0] in_data;
    logic       commit;
    logic [3:0] o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11;
    logic       upd;
    logic       err;
    logic [47:0] outs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign outs = {o11, o10, o9, o8, o7, o6, o5, o4, o3, o2, o1, o0};

    phan_kenh_12kenh #(
        .W   (4),
        .NCH (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
`ifndef PHANKENH_AUTO_SCAN_EN
        .commit   (commit),
`endif
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .o4       (o4),
        .o5       (o5),
        .o6       (o6),
        .o7       (o7),
        .o8       (o8),
        .o9       (o9),
        .o10      (o10),
        .o11      (o11),
        .upd      (upd),
        .err      (err)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [3:0]  sel;
        logic [3:0]  data;
        logic        commit;
        logic        exp_ready;
        logic        exp_upd;
        logic        exp_err;
        logic [47:0] exp_o;
    } vec_t;

    vec_t vecs [13];

    task automatic idle();
        in_valid = 1'b0;
        in_sel   = 4'd0;
        in_data  = 4'd0;
        commit   = 1'b0;
    endtask

    task automatic check_post(input string tag, input logic r, input logic u, input logic e,
                              input logic [47:0] o);
        check({tag, " ready"}, {47'd0, in_ready}, {47'd0, r});
        check({tag, " upd"},   {47'd0, upd},      {47'd0, u});
        check({tag, " err"},   {47'd0, err},      {47'd0, e});
        check({tag, " outs"},  outs, o);
    endtask

    initial begin
        //                valid sel    data   cmt  rdy  upd  err  outputs {o11..o0}
        vecs[0]  = '{1'b1, 4'd3,  4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 48'h0};
        vecs[1]  = '{1'b1, 4'd11, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 48'h0};
        vecs[2]  = '{1'b0, 4'd0,  4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0};
        vecs[3]  = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h5000_0000_A000};
        vecs[4]  = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h5000_0000_A000};
        vecs[5]  = '{1'b1, 4'd7,  4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 48'h5000_0000_A000};
        vecs[6]  = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 48'h5000_C000_A000};
        vecs[7]  = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 48'h5000_C000_A000};
        vecs[8]  = '{1'b1, 4'd13, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 48'h5000_C000_A000};
        vecs[9]  = '{1'b0, 4'd0,  4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 48'h5000_C000_A000};
        vecs[10] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 48'h5000_C000_A000};
        vecs[11] = '{1'b0, 4'd0,  4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 48'h5000_C000_A000};
        vecs[12] = '{1'b0, 4'd0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 48'h5000_C000_A000};

        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        check_post("reset", 1'b1, 1'b0, 1'b0, 48'h0);
        rst = 1'b0;

`ifndef PHANKENH_AUTO_SCAN_EN
        // Write/commit flow, illegal index and back-to-back commits.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid = vecs[i].valid;
            in_sel   = vecs[i].sel;
            in_data  = vecs[i].data;
            commit   = vecs[i].commit;
            @(posedge clk);
            #1;
            idle();
            check_post($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_upd,
                       vecs[i].exp_err, vecs[i].exp_o);
        end

        // Commit held high: COMMIT, FILL, COMMIT, FILL.
        @(negedge clk);
        commit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_post($sformatf("held%0d", i), i[0], i[0], 1'b1, 48'h5000_C000_A000);
        end
        @(negedge clk);
        idle();

        // Reset asserted in the middle of a COMMIT cycle aborts the copy.
        @(negedge clk);
        commit = 1'b1;
        @(posedge clk);
        #1;
        check("midrst pre ready", {47'd0, in_ready}, 48'd0);
        #2;
        rst = 1'b1;
        #1;
        check_post("midrst", 1'b1, 1'b0, 1'b0, 48'h0);
        @(negedge clk);
        idle();
        rst = 1'b0;

        // Shadow was cleared too: a fresh commit still shows all zeros.
        @(negedge clk);
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
        @(posedge clk);
        #1;
        check_post("post-rst commit", 1'b1, 1'b1, 1'b0, 48'h0);
`else
        // Auto-scan: 12 words fill channels 0..11 and trigger the commit.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sel   = 4'd15;
            in_data  = 4'(k + 1);
        end
        @(posedge clk);
        #1;
        idle();
        check("scan commit ready", {47'd0, in_ready}, 48'd0);
        @(posedge clk);
        #1;
        check_post("scan", 1'b1, 1'b1, 1'b0, 48'hCBA9_8765_4321);
        // 13th word goes to channel 0 of the shadow; outputs hold.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'hD;
        @(posedge clk);
        #1;
        idle();
        check_post("scan 13th", 1'b1, 1'b0, 1'b0, 48'hCBA9_8765_4321);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
